// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial test-pattern transmitter, MSB-first with repeat and idle gap
module seq_pattern_tx #(
    parameter int   WIDTH    = 8,
    parameter int   LEN_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP      = 2,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             outp,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam int KW       = $clog2(WIDTH) + 1;
    localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [KW-1:0]      len_q, len_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               outp_q, outp_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic [KW-1:0]      eff_len;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        if (pat_len == '0 || pat_len > LEN_W'(WIDTH)) begin
            eff_len = KW'(WIDTH);
        end else begin
            eff_len = KW'(pat_len);
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        k_d     = k_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (pat_valid) begin
                    state_d = S_SHIFT;
                    pat_d   = pat_data;
                    len_d   = eff_len;
                    rep_d   = rep_cnt;
                    k_d     = '0;
                end
            end
            S_SHIFT: begin
                if (k_q == len_q - KW'(1)) begin
                    if (rep_q != '0) begin
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            k_d   = '0;
                            rep_d = rep_q - CNT_W'(1);
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_LAST)) begin
                    state_d = S_SHIFT;
                    k_d     = '0;
                    rep_d   = rep_q - CNT_W'(1);
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers are loaded from the next-state view so each bit lines up with its SHIFT cycle.
    always_comb begin
        shifted     = pat_d >> (len_d - KW'(1) - k_d);
        out_valid_d = (state_d == S_SHIFT);
        outp_d      = out_valid_d ? shifted[0] : IDLE_BIT;
        done_d      = out_valid_d && (k_d == len_d - KW'(1)) && (rep_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            k_q         <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            outp_q      <= IDLE_BIT;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            k_q         <= k_d;
            rep_q       <= rep_d;
            gap_q       <= gap_d;
            outp_q      <= outp_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign pat_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign outp      = outp_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard bench for seq_pattern_tx
module tb_seq_pattern_tx;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pat_data;
    logic [3:0] pat_len;
    logic [3:0] rep_cnt;
    logic       pat_valid;
    logic       pat_ready;
    logic       outp;
    logic       out_valid;
    logic       busy;
    logic       done;

    seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP(GAP), .IDLE_BIT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .rep_cnt   (rep_cnt),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .outp      (outp),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic b;
        logic d;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   in_frame = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (!in_frame && out_valid) begin
                in_frame = 1;
                tests++;
                if (start_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_frame cyc=%0d: out_valid with no load pending", cyc);
                end else begin
                    int s;
                    s = start_q.pop_front();
                    if (cyc != s) begin
                        fails++;
                        $display("FAIL start_latency: first bit at cycle %0d, required %0d", cyc, s);
                    end
                end
            end
            if (in_frame) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_output cyc=%0d: valid=%0b outp=%0b done=%0b beyond expected stream",
                             cyc, out_valid, outp, done);
                    in_frame = 0;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    tests++;
                    if ({out_valid, outp, done} !== {e.v, e.b, e.d}) begin
                        fails++;
                        $display("FAIL stream cyc=%0d: got valid/outp/done=%0b%0b%0b, required %0b%0b%0b",
                                 cyc, out_valid, outp, done, e.v, e.b, e.d);
                    end
                    if (e.last) in_frame = 0;
                end
            end else if (done) begin
                tests++;
                fails++;
                $display("FAIL stray_done cyc=%0d: done=1 outside a frame", cyc);
            end
        end
    end

    task automatic push_frame(input logic [15:0] b, input int n, input int rep);
        exp_t e;
        for (int r = 0; r <= rep; r++) begin
            for (int k = 0; k < n; k++) begin
                e.v    = 1'b1;
                e.b    = b[n-1-k];
                e.d    = (r == rep) && (k == n - 1);
                e.last = e.d;
                exp_q.push_back(e);
            end
            if (r < rep) begin
                for (int g = 0; g < GAP; g++) begin
                    e = '0;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic load(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r,
                        input logic [15:0] b, input int n, input bit push);
        int t = 0;
        @(negedge clk);
        while (!pat_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!pat_ready) begin
            tests++;
            fails++;
            $display("FAIL load_ready: pat_ready=%0b after %0d cycles, required 1", pat_ready, t);
        end else begin
            pat_data  = d;
            pat_len   = l;
            rep_cnt   = r;
            pat_valid = 1'b1;
            if (push) push_frame(b, n, int'(r));
            @(posedge clk);
            #1;
            start_q.push_back(cyc);
            pat_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst       = 1'b1;
        pat_valid = 1'b1;
        pat_data  = 8'hFF;
        pat_len   = 4'd8;
        rep_cnt   = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({outp, out_valid, done, busy, pat_ready} !== 5'b00001) begin
                fails++;
                $display("FAIL reset_state[%0d]: outp/valid/done/busy/ready=%0b%0b%0b%0b%0b, required 00001",
                         i, outp, out_valid, done, busy, pat_ready);
            end
        end
        rst       = 1'b0;
        pat_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL load_during_reset: busy=%0b out_valid=%0b, required 0 0", busy, out_valid);
        end

        load(8'b1011_0010, 4'd8, 4'd0, 16'b1011_0010, 8, 1);
        load(8'b1010_1110, 4'd3, 4'd2, 16'b110, 3, 1);
        load(8'hA5, 4'd0, 4'd0, 16'h00A5, 8, 1);
        load(8'hA5, 4'd12, 4'd0, 16'h00A5, 8, 1);
        load(8'h01, 4'd1, 4'd0, 16'h0001, 1, 1);
        load(8'h01, 4'd1, 4'd15, 16'h0001, 1, 1);
        drain();

        load(8'hF0, 4'd8, 4'd0, 16'h00F0, 8, 1);
        pat_data = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            pat_valid = ~pat_valid;
            tests++;
            if (busy !== 1'b1 || pat_ready !== 1'b0) begin
                fails++;
                $display("FAIL busy_isolation[%0d]: busy=%0b pat_ready=%0b, required 1 0", i, busy, pat_ready);
            end
        end
        pat_valid = 1'b0;
        drain();

        for (int k = 0; k < 5; k++) begin
            e.v    = 1'b1;
            e.b    = 1'b1;
            e.d    = 1'b0;
            e.last = (k == 4);
            exp_q.push_back(e);
        end
        load(8'hFF, 4'd8, 4'd0, 16'h00FF, 8, 0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({out_valid, outp, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL midframe_reset: valid/outp/busy/done=%0b%0b%0b%0b, required 0000",
                     out_valid, outp, busy, done);
        end
        #1;
        rst = 1'b0;
        load(8'h81, 4'd8, 4'd0, 16'h0081, 8, 1);
        drain();

        tests++;
        if (start_q.size() != 0) begin
            fails++;
            $display("FAIL frames_missing: %0d loads produced no output, required 0", start_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
